aes_key_sched_ctrl: RTL and testbench

//  Rekey controller for the unrolled AES-128 round pipeline (stage 0 = initial AddRoundKey .. stage NR = last round).

---
 rtl/aes_key_sched_ctrl_pkg.sv | 46 ++++
 rtl/aes_key_sched_ctrl_if.sv | 36 +++
 rtl/aes_key_sched_ctrl_expand_step.sv | 28 ++
 rtl/aes_key_sched_ctrl.sv | 148 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared types, round-constant table and GF(2^8) helpers for the AES-128 rekey controller.
package aes_key_sched_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    EXPAND = 2'd2,
    ZERO   = 2'd3
  } key_sched_state_t;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Indices outside 1..10 yield zero; the last expansion step's result is never used.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    if (idx >= 4'd1 && idx <= 4'd10) return RCON[idx];
    return 8'h00;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Host key port, pipeline input gate and per-stage round-key bus of the rekey controller.
// The zeroize request exists only when AES_KEY_ZEROIZE_EN is defined.
interface aes_key_sched_ctrl_if #(
  parameter int NR = 10
);
  logic          key_valid;
  logic          key_ready;
  logic [127:0]  key_in;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  round_key;
  logic [NR:0]   set_key;
  logic [NR:0]   set_inv_key;
  logic          key_loaded;
  logic          busy;
`ifdef AES_KEY_ZEROIZE_EN
  logic          zeroize;
`endif

  modport master (
`ifdef AES_KEY_ZEROIZE_EN
    output zeroize,
`endif
    output key_valid, key_in, in_valid,
    input  key_ready, in_ready, round_key, set_key, set_inv_key, key_loaded, busy
  );

  modport slave (
`ifdef AES_KEY_ZEROIZE_EN
    input  zeroize,
`endif
    input  key_valid, key_in, in_valid,
    output key_ready, in_ready, round_key, set_key, set_inv_key, key_loaded, busy
  );

endinterface

// File: rtl/aes_key_sched_ctrl_expand_step.sv
// One AES-128 key-expansion step: RotWord, SubWord (four S-boxes), rcon, XOR chain.
module aes_key_expand_step
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, t_w;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_w[8*i +: 8] = sbox(rot_w[8*i +: 8]);
  end

  assign t_w = sub_w ^ {rcon, 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Rekey controller: gates the round pipeline, drains it, then broadcasts one round key per cycle.
// Optional AES_KEY_ZEROIZE_EN adds a zeroize request that wipes every stage key.
module aes_key_sched_ctrl
  import aes_key_sched_ctrl_pkg::*;
#(
  parameter int NR         = 10,
  parameter int PIPE_DEPTH = 11
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_key_sched_ctrl_if.slave kif
);

  localparam int          CW       = $clog2(PIPE_DEPTH + 1);
  localparam int          RW       = $clog2(NR + 2);
  localparam logic [NR:0] ONE_HOT0 = {{NR{1'b0}}, 1'b1};

  if (NR != 10) begin : g_nr_check
    $error("aes_key_sched_ctrl: only NR=10 (AES-128) is supported");
  end

  key_sched_state_t state_q, state_d;
  logic [127:0]     cur_key_q;
  logic [127:0]     next_key;
  logic [CW-1:0]    drain_cnt_q;
  logic [RW-1:0]    rnd_q;
  logic [127:0]     round_key_q;
  logic [NR:0]      set_key_q, set_inv_key_q;
  logic             key_loaded_q;
  logic             accept_key, start_zero, key_ready_c;
  logic             zero_start, zero_mode_q;

  // in_valid never affects the gate; upstream simply holds blocks while in_ready is low.
  logic unused_in_valid;
  assign unused_in_valid = kif.in_valid;

`ifdef AES_KEY_ZEROIZE_EN
  logic zero_req_q;
  assign zero_start = kif.zeroize || zero_req_q;

  // zero_mode_q: the running drain ends in ZERO; zero_req_q: zeroize seen while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_req_q  <= 1'b0;
      zero_mode_q <= 1'b0;
    end else if (start_zero) begin
      zero_req_q  <= 1'b0;
      zero_mode_q <= 1'b1;
    end else begin
      if (state_q == ZERO) zero_mode_q <= 1'b0;
      if (kif.zeroize && state_q != IDLE && !zero_mode_q) zero_req_q <= 1'b1;
    end
  end
`else
  assign zero_start  = 1'b0;
  assign zero_mode_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept_key  = 1'b0;
    start_zero  = 1'b0;
    key_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (zero_start) begin
          start_zero = 1'b1;
          state_d    = DRAIN;
        end else begin
          key_ready_c = 1'b1;
          if (kif.key_valid) begin
            accept_key = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN:   if (drain_cnt_q == '0) state_d = zero_mode_q ? ZERO : EXPAND;
      EXPAND:  if (rnd_q == RW'(NR)) state_d = IDLE;
`ifdef AES_KEY_ZEROIZE_EN
      ZERO:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  aes_key_expand_step u_expand (
    .key      (cur_key_q),
    .rcon     (rcon_of(4'(rnd_q + 1'b1))),
    .next_key (next_key)
  );

  // Strobes default low every cycle so each one lasts exactly one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_key_q     <= '0;
      drain_cnt_q   <= '0;
      rnd_q         <= '0;
      round_key_q   <= '0;
      set_key_q     <= '0;
      set_inv_key_q <= '0;
      key_loaded_q  <= 1'b0;
    end else begin
      set_key_q     <= '0;
      set_inv_key_q <= '0;
      if (accept_key) begin
        cur_key_q    <= kif.key_in;
        key_loaded_q <= 1'b0;
        drain_cnt_q  <= CW'(PIPE_DEPTH - 1);
      end
      if (start_zero) drain_cnt_q <= CW'(PIPE_DEPTH - 1);
      if (state_q == DRAIN) begin
        if (drain_cnt_q != '0) drain_cnt_q <= drain_cnt_q - 1'b1;
        rnd_q <= '0;
      end
      if (state_q == EXPAND) begin
        round_key_q   <= cur_key_q;
        set_key_q     <= ONE_HOT0 << rnd_q;
        set_inv_key_q <= ONE_HOT0 << (RW'(NR) - rnd_q);
        cur_key_q     <= next_key;
        rnd_q         <= rnd_q + 1'b1;
        if (rnd_q == RW'(NR)) key_loaded_q <= 1'b1;
      end
`ifdef AES_KEY_ZEROIZE_EN
      if (state_q == ZERO) begin
        round_key_q   <= '0;
        set_key_q     <= '1;
        set_inv_key_q <= '1;
        cur_key_q     <= '0;
        key_loaded_q  <= 1'b0;
      end
`endif
    end
  end

  assign kif.key_ready   = key_ready_c;
  assign kif.in_ready    = (state_q == IDLE) && key_loaded_q && !kif.key_valid && !zero_start;
  assign kif.busy        = (state_q != IDLE);
  assign kif.round_key   = round_key_q;
  assign kif.set_key     = set_key_q;
  assign kif.set_inv_key = set_inv_key_q;
  assign kif.key_loaded  = key_loaded_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: cycle-level behavioural model plus FIPS-197 literal and end-to-end checks.
module tb_aes_key_sched_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_key_sched_ctrl_if #(.NR(NR)) kif ();

  aes_key_sched_ctrl #(.NR(NR), .PIPE_DEPTH(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;
  always @(posedge clk) n_cyc <= n_cyc + 1;

  logic [7:0]   sb [0:255];
  logic [7:0]   isb [0:255];
  logic [127:0] enc_stage [0:10];
  logic [127:0] dec_stage [0:10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion over a word array; returns round key r.
  function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   b;
    int           src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        b   = s[127-8*(4*src+r) -: 8];
        o[127-8*(4*c+r) -: 8] = inv ? isb[b] : sb[b];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   cf [0:3];
    logic [7:0]   acc;
    if (inv) begin cf[0] = 14; cf[1] = 11; cf[2] = 13; cf[3] = 9; end
    else     begin cf[0] = 2;  cf[1] = 3;  cf[2] = 1;  cf[3] = 1; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(s[127-8*(4*c+j) -: 8], cf[(j - r + 4) % 4]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ enc_stage[0];
    for (int r = 1; r < 10; r++) s = mix(sub_shift(s, 1'b0), 1'b0) ^ enc_stage[r];
    return sub_shift(s, 1'b0) ^ enc_stage[10];
  endfunction

  function automatic logic [127:0] decrypt(input logic [127:0] c);
    logic [127:0] s;
    s = c ^ dec_stage[0];
    for (int r = 1; r < 10; r++) s = mix(sub_shift(s, 1'b1) ^ dec_stage[r], 1'b1);
    return sub_shift(s, 1'b1) ^ dec_stage[10];
  endfunction

  // Behavioural model: a load accepted at cycle T strobes round r at T+13+r and is loaded at T+23.
  bit           m_active = 0, m_zero = 0, m_loaded = 0;
  int           m_T = 0;
  logic [127:0] m_bus = '0;
  logic [127:0] m_rk [0:10];

  initial forever begin
    int         k;
    bit         strobe_now, zero_now, idle, zin;
    logic [10:0] exp_sk, exp_isk;
    @(negedge clk);
    strobe_now = 0; zero_now = 0; k = 0;
    if (!rst_n) begin
      m_active = 0; m_zero = 0; m_loaded = 0; m_bus = '0;
    end else if (m_active) begin
      if (m_zero) begin
        if (n_cyc == m_T + 13) begin
          zero_now = 1; m_active = 0; m_zero = 0; m_loaded = 0; m_bus = '0;
        end
      end else begin
        k = n_cyc - m_T - 13;
        if (k >= 0 && k <= 10) begin strobe_now = 1; m_bus = m_rk[k]; end
        if (k == 10) begin m_active = 0; m_loaded = 1; end
      end
    end
    exp_sk  = zero_now ? 11'h7ff : (strobe_now ? (11'd1 << k) : 11'd0);
    exp_isk = zero_now ? 11'h7ff : (strobe_now ? (11'd1 << (10 - k)) : 11'd0);
    idle = !m_active;
`ifdef AES_KEY_ZEROIZE_EN
    zin = kif.zeroize;
`else
    zin = 0;
`endif
    chk("key_ready",   {127'd0, kif.key_ready},  {127'd0, idle && !zin});
    chk("in_ready",    {127'd0, kif.in_ready},   {127'd0, idle && m_loaded && !kif.key_valid && !zin});
    chk("busy",        {127'd0, kif.busy},       {127'd0, !idle});
    chk("key_loaded",  {127'd0, kif.key_loaded}, {127'd0, m_loaded});
    chk("set_key",     {117'd0, kif.set_key},     {117'd0, exp_sk});
    chk("set_inv_key", {117'd0, kif.set_inv_key}, {117'd0, exp_isk});
    chk("round_key",   kif.round_key, m_bus);
    for (int r = 0; r <= 10; r++) begin
      if (kif.set_key[r] === 1'b1)     enc_stage[r] = kif.round_key;
      if (kif.set_inv_key[r] === 1'b1) dec_stage[r] = kif.round_key;
    end
    if (rst_n && idle) begin
      if (zin) begin
        m_active = 1; m_zero = 1; m_T = n_cyc;
      end else if (kif.key_valid) begin
        m_active = 1; m_T = n_cyc; m_loaded = 0;
        for (int r = 0; r <= 10; r++) m_rk[r] = model_rk(kif.key_in, r);
      end
    end
  end

  task automatic send_key(input logic [127:0] k);
    kif.key_valid = 1'b1;
    kif.key_in    = k;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kif.key_ready) begin
        @(posedge clk); #1;
        kif.key_valid = 1'b0;
        return;
      end
    end
    chk("key_accept_timeout", 128'd0, 128'd1);
    kif.key_valid = 1'b0;
  endtask

  task automatic wait_loaded(output int cyc, output int lows);
    cyc = -1; lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kif.key_loaded) begin cyc = n_cyc; return; end
      if (!kif.in_ready) lows++;
    end
    chk("load_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    int t0, t1, tl, lows;
    logic [127:0] ct;
    rst_n = 1'b0;
    kif.key_valid = 0; kif.key_in = '0; kif.in_valid = 0;
`ifdef AES_KEY_ZEROIZE_EN
    kif.zeroize = 0;
`endif
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = b; isb[b] = 8'(x);
    end
    chk("model_rk0",  model_rk(K_FIPS, 0),  K_FIPS);
    chk("model_rk1",  model_rk(K_FIPS, 1),  128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_rk10", model_rk(K_FIPS, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    kif.in_valid = 1'b1;

    // FIPS-197 A.1 load with the pipeline input continuously offered
    send_key(K_FIPS);
    t0 = m_T;
    wait_loaded(tl, lows);
    #1;
    chk("load_latency",   128'(tl - t0), 128'd23);
    chk("in_ready_lows",  128'(lows + 1), 128'd23);
    chk("in_ready_after", {127'd0, kif.in_ready}, 128'd1);
    chk("stage_enc0",     enc_stage[0],  K_FIPS);
    chk("stage_enc1",     enc_stage[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("stage_enc10",    enc_stage[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("stage_dec0",     dec_stage[0],  128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // End-to-end encrypt/decrypt through the installed stage keys
    @(posedge clk); #1;
    send_key(K_SEQ);
    wait_loaded(tl, lows);
    #1;
    ct = encrypt(PT);
    chk("e2e_encrypt", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("e2e_decrypt", decrypt(ct), PT);

    // Back-to-back keys: the second is held off until the first IDLE cycle
    @(posedge clk); #1;
    send_key(128'h3c4fcf098815f7aba6d2ae2816157e2b);
    t0 = m_T;
    send_key(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    t1 = m_T;
    chk("b2b_accept_gap", 128'(t1 - t0), 128'd23);
    wait_loaded(tl, lows);
    #1;
    for (int r = 0; r <= 10; r++)
      chk($sformatf("b2b_stage_enc%0d", r), enc_stage[r], model_rk(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, r));

    // Asynchronous reset during EXPAND at rnd=5, then a fresh load
    @(posedge clk); #1;
    send_key(128'hffeeddccbbaa99887766554433221100);
    repeat (16) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_key_loaded", {127'd0, kif.key_loaded}, 128'd0);
    chk("abort_set_key",    {117'd0, kif.set_key}, 128'd0);
    chk("abort_set_inv",    {117'd0, kif.set_inv_key}, 128'd0);
    chk("abort_round_key",  kif.round_key, 128'd0);
    chk("abort_busy",       {127'd0, kif.busy}, 128'd0);
    chk("abort_key_ready",  {127'd0, kif.key_ready}, 128'd1);
    chk("abort_in_ready",   {127'd0, kif.in_ready}, 128'd0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_key(K_FIPS);
    t0 = m_T;
    wait_loaded(tl, lows);
    #1;
    chk("reload_latency",     128'(tl - t0), 128'd23);
    chk("reload_stage_enc10", enc_stage[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize with a key schedule installed
    @(posedge clk); #1;
    kif.zeroize = 1'b1;
    @(posedge clk); #1;
    kif.zeroize = 1'b0;
    tl = -1;
    for (int i = 0; i < 30 && tl < 0; i++) begin
      @(negedge clk);
      if (kif.set_key === 11'h7ff) tl = i;
    end
    chk("zero_seen",       128'(tl >= 0), 128'd1);
    chk("zero_round_key",  kif.round_key, 128'd0);
    chk("zero_set_inv",    {117'd0, kif.set_inv_key}, 128'h7ff);
    chk("zero_key_loaded", {127'd0, kif.key_loaded}, 128'd0);
    chk("zero_in_ready",   {127'd0, kif.in_ready}, 128'd0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
